// File: rtl/timer_pkg.sv
// ============================================================================
// timer_pkg : shared mode encoding and display blink masks for timer_ctrl
// Rev 1.0   : initial release
// ============================================================================
`default_nettype none

package timer_pkg;

    typedef enum logic [2:0] {
        RUN   = 3'd0,
        PAUSE = 3'd1,
        SET_H = 3'd2,
        SET_M = 3'd3,
        SET_S = 3'd4
    } mode_t;

    // Digit-block bit positions, shared with the display multiplexer
    localparam int HOURS_LSB   = 4;
    localparam int MINUTES_LSB = 2;
    localparam int SECONDS_LSB = 0;

    localparam logic [5:0] MASK_SET_H = 6'b110000;
    localparam logic [5:0] MASK_SET_M = 6'b001100;
    localparam logic [5:0] MASK_SET_S = 6'b000011;

    function automatic logic [5:0] field_mask(input mode_t m);
        case (m)
            SET_H:   return MASK_SET_H;
            SET_M:   return MASK_SET_M;
            SET_S:   return MASK_SET_S;
            default: return 6'b000000;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/timer_ctrl_if.sv
// ============================================================================
// timer_ctrl_if : raw keys in, datapath/display controls out
// Rev 1.0       : initial release
// ============================================================================
`default_nettype none

interface timer_ctrl_if;
    import timer_pkg::*;

    logic       key_pause;
    logic       key_program;
    logic       key_up;
    logic       run_en;
    logic       inc_hours;
    logic       inc_minutes;
    logic       inc_seconds;
    logic       clr_count;
    mode_t      mode;
    logic [5:0] blink_mask;

    modport master (
        output key_pause, key_program, key_up,
        input  run_en, inc_hours, inc_minutes, inc_seconds, clr_count, mode, blink_mask
    );

    modport slave (
        input  key_pause, key_program, key_up,
        output run_en, inc_hours, inc_minutes, inc_seconds, clr_count, mode, blink_mask
    );
endinterface

`default_nettype wire

// File: rtl/key_debounce.sv
// ============================================================================
// key_debounce : 2-flop synchronizer, stability counter, press-event pulse
// Rev 1.0      : initial release
// ============================================================================
`default_nettype none

module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic level,
    output logic press
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_a;
    logic             sync_b;
    logic             level_d;
    logic [CNT_W-1:0] stable_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_a     <= 1'b1;
            sync_b     <= 1'b1;
            level      <= 1'b1;
            level_d    <= 1'b1;
            press      <= 1'b0;
            stable_cnt <= '0;
        end else begin
            sync_a  <= key_n;
            sync_b  <= sync_a;
            level_d <= level;
            // Falling edge of the accepted level, one register after the update
            press   <= level_d & ~level;
            if (sync_b == level) begin
                stable_cnt <= '0;
            end else if (stable_cnt == CNT_LAST) begin
                level      <= sync_b;
                stable_cnt <= '0;
            end else begin
                stable_cnt <= stable_cnt + 1'b1;
            end
        end
    end
endmodule

`default_nettype wire

// File: rtl/timer_ctrl.sv
// ============================================================================
// timer_ctrl : key conditioning, run/pause/set mode FSM, blink and increments
// Optional auto-repeat on the up key: define TIMER_CTRL_AUTOREPEAT_EN
// Rev 1.0    : initial release
// ============================================================================
`default_nettype none

module timer_ctrl
    import timer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int BLINK_CYCLES    = 12500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic        clk,
    input  logic        rst,
    timer_ctrl_if.slave bus
);
    localparam int KEY_PAUSE   = 0;
    localparam int KEY_PROGRAM = 1;
    localparam int KEY_UP      = 2;
    localparam int BLINK_W     = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);

    logic [2:0]         key_raw;
    logic [2:0]         key_level;
    logic [2:0]         key_press;
    mode_t              state;
    mode_t              state_next;
    logic [2:0]         inc_next;      // {hours, minutes, seconds}
    logic               clr_next;
    logic               state_chg;
    logic               rpt_fire;
    logic               run_q;
    logic [2:0]         inc_q;
    logic               clr_q;
    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_phase;
    logic [5:0]         mask_q;

    assign key_raw = {bus.key_up, bus.key_program, bus.key_pause};

    for (genvar gi = 0; gi < 3; gi++) begin : g_key
        key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
            .clk   (clk),
            .rst   (rst),
            .key_n (key_raw[gi]),
            .level (key_level[gi]),
            .press (key_press[gi])
        );
    end

    // Priority: program, then pause, then up / repeat
    always_comb begin
        state_next = state;
        inc_next   = 3'b000;
        clr_next   = 1'b0;
        if (key_press[KEY_PROGRAM]) begin
            case (state)
                RUN, PAUSE: state_next = SET_H;
                SET_H:      state_next = SET_M;
                SET_M:      state_next = SET_S;
                SET_S: begin
                    state_next = RUN;
                    clr_next   = 1'b1;
                end
                default:    state_next = RUN;
            endcase
        end else if (key_press[KEY_PAUSE]) begin
            if (state == RUN)
                state_next = PAUSE;
            else if (state == PAUSE)
                state_next = RUN;
        end else if (key_press[KEY_UP] || rpt_fire) begin
            case (state)
                SET_H:   inc_next = 3'b100;
                SET_M:   inc_next = 3'b010;
                SET_S:   inc_next = 3'b001;
                default: inc_next = 3'b000;
            endcase
        end
    end

    assign state_chg = (state_next != state);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            run_q <= 1'b1;
            inc_q <= 3'b000;
            clr_q <= 1'b0;
        end else begin
            state <= state_next;
            run_q <= (state_next == RUN);
            inc_q <= inc_next;
            clr_q <= clr_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            mask_q      <= 6'b000000;
        end else begin
            if (state_chg) begin
                blink_cnt   <= '0;
                blink_phase <= 1'b0;
            end else if (blink_cnt == BLINK_LAST) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
            mask_q <= blink_phase ? field_mask(state) : 6'b000000;
        end
    end

`ifdef TIMER_CTRL_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);
    localparam logic [RPT_W-1:0] RPT_DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

    logic [RPT_W-1:0] rpt_cnt;
    logic             rpt_first;
    logic             in_set;
    logic             unused_levels;

    assign in_set        = (state inside {SET_H, SET_M, SET_S});
    assign unused_levels = ^key_level[1:0];
    // First repeat waits the long delay, later ones use the short period
    assign rpt_fire      = in_set && !key_level[KEY_UP] && !key_press[KEY_UP] &&
                           (rpt_cnt == (rpt_first ? RPT_DELAY_LAST : RPT_PERIOD_LAST));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rpt_cnt   <= '0;
            rpt_first <= 1'b1;
        end else if (state_chg || !in_set || key_level[KEY_UP] || key_press[KEY_UP]) begin
            rpt_cnt   <= '0;
            rpt_first <= 1'b1;
        end else if (rpt_fire) begin
            rpt_cnt   <= '0;
            rpt_first <= 1'b0;
        end else begin
            rpt_cnt <= rpt_cnt + 1'b1;
        end
    end
`else
    localparam int UNUSED_REPEAT_CFG = REPEAT_DELAY + REPEAT_PERIOD;
    logic unused_levels;

    assign unused_levels = ^key_level;
    assign rpt_fire      = 1'b0;
`endif

    assign bus.mode        = state;
    assign bus.run_en      = run_q;
    assign bus.inc_hours   = inc_q[2];
    assign bus.inc_minutes = inc_q[1];
    assign bus.inc_seconds = inc_q[0];
    assign bus.clr_count   = clr_q;
    assign bus.blink_mask  = mask_q;
endmodule

`default_nettype wire

// File: tb/tb_timer_ctrl.sv
// ============================================================================
// tb_timer_ctrl : directed self-checking bench for timer_ctrl
// Rev 1.0       : initial release
// ============================================================================
`default_nettype none

module tb_timer_ctrl;
    import timer_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    timer_ctrl_if bus ();

    timer_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .BLINK_CYCLES    (8),
        .REPEAT_DELAY    (20),
        .REPEAT_PERIOD   (5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pulse monitors
    int         n_h = 0, n_m = 0, n_s = 0, n_clr = 0, excl_err = 0, wide_err = 0;
    logic [2:0] mode_at_clr = 3'd7;
    logic [3:0] prev_pulses = 4'b0000;

    always @(negedge clk) begin
        logic [3:0] cur;
        cur = {bus.inc_hours, bus.inc_minutes, bus.inc_seconds, bus.clr_count};
        if (cur[3]) n_h++;
        if (cur[2]) n_m++;
        if (cur[1]) n_s++;
        if (cur[0]) begin
            n_clr++;
            mode_at_clr = bus.mode;
        end
        if ($countones(cur) > 1) excl_err++;
        if ((cur & prev_pulses) != 4'b0000) wide_err++;
        prev_pulses = cur;
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_key(input int key, input logic v);
        case (key)
            0:       bus.key_pause   = v;
            1:       bus.key_program = v;
            default: bus.key_up      = v;
        endcase
    endtask

    task automatic press(input int key);
        set_key(key, 1'b0);
        cycles(12);
        set_key(key, 1'b1);
        cycles(12);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_h, base_m, base_s, base_clr, blank_err, show_err, first, npulse;
        int offs[8];

        bus.key_pause = 1'b1; bus.key_program = 1'b1; bus.key_up = 1'b1;
        rst = 1'b1;
        cycles(3);
        check("reset_mode",  bus.mode, RUN);
        check("reset_run",   bus.run_en, 1);
        check("reset_blink", bus.blink_mask, 0);
        check("reset_pulse", {bus.inc_hours, bus.inc_minutes, bus.inc_seconds, bus.clr_count}, 0);
        rst = 1'b0;
        cycles(2);

        // Bounce: short toggles, then a steady press
        for (int i = 0; i < 4; i++) begin
            bus.key_pause = (i % 2 == 1);
            cycles(2);
        end
        bus.key_pause = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #2;
            if (k == 7) check("bounce_before", bus.mode, RUN);
            if (k == 8) begin
                check("bounce_mode", bus.mode, PAUSE);
                check("bounce_run",  bus.run_en, 0);
            end
        end
        cycles(10);
        check("bounce_single", bus.mode, PAUSE);
        bus.key_pause = 1'b1;
        cycles(12);

        base_h = n_h; base_m = n_m; base_s = n_s;
        press(2);
        check("up_in_pause", (n_h - base_h) + (n_m - base_m) + (n_s - base_s), 0);
        check("up_in_pause_mode", bus.mode, PAUSE);

        // Program and pause together in PAUSE; then blink timing in SET_H
        bus.key_pause = 1'b0; bus.key_program = 1'b0;
        blank_err = 0; show_err = 0;
        for (int k = 1; k <= 24; k++) begin
            @(posedge clk); #2;
            if (k == 8) begin
                check("prio_mode", bus.mode, SET_H);
                check("prio_run",  bus.run_en, 0);
            end
            if (k == 12) begin
                bus.key_pause = 1'b1; bus.key_program = 1'b1;
            end
            if (k >= 9 && k <= 16 && bus.blink_mask != 6'b000000) blank_err++;
            if (k >= 17 && k <= 24 && bus.blink_mask != 6'b110000) show_err++;
        end
        check("blink_blank_phase", blank_err, 0);
        check("blink_hours_phase", show_err, 0);
        cycles(12);

        press(0);
        check("pause_in_set", bus.mode, SET_H);
        press(1);
        check("set_m_mode", bus.mode, SET_M);

        base_h = n_h; base_m = n_m; base_s = n_s;
        for (int i = 0; i < 3; i++) press(2);
        check("inc_minutes", n_m - base_m, 3);
        check("inc_hours_idle", n_h - base_h, 0);
        check("inc_seconds_idle", n_s - base_s, 0);

        // Asynchronous reset mid-SET_M with a pause press pending
        base_m = n_m;
        bus.key_pause = 1'b0;
        cycles(5);
        #2 rst = 1'b1;
        #1;
        check("rst_async_mode",  bus.mode, RUN);
        check("rst_async_run",   bus.run_en, 1);
        check("rst_async_blink", bus.blink_mask, 0);
        bus.key_pause = 1'b1;
        cycles(2);
        rst = 1'b0;
        cycles(20);
        check("rst_event_lost", bus.mode, RUN);
        check("rst_no_inc", n_m - base_m, 0);

        // Set sequence up to SET_S
        base_clr = n_clr;
        press(1);
        check("seq_h", bus.mode, SET_H);
        press(1);
        check("seq_m", bus.mode, SET_M);
        press(1);
        check("seq_s", bus.mode, SET_S);
        check("seq_s_run", bus.run_en, 0);

        // Held up key in SET_S
        base_s = n_s; first = -1; npulse = 0;
        bus.key_up = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk); #2;
            if (k == 50) bus.key_up = 1'b1;
            if (bus.inc_seconds) begin
                if (first < 0) first = k;
                if (k - first < 40) begin
                    if (npulse < 8) offs[npulse] = k - first;
                    npulse++;
                end
            end
        end
        cycles(12);
        check("up_latency", first, 8);
`ifdef TIMER_CTRL_AUTOREPEAT_EN
        check("rpt_count", npulse, 5);
        check("rpt_off1", offs[1], 20);
        check("rpt_off2", offs[2], 25);
        check("rpt_off3", offs[3], 30);
        check("rpt_off4", offs[4], 35);
`else
        check("rpt_count", npulse, 1);
        check("rpt_total", n_s - base_s, 1);
`endif

        press(1);
        check("seq_run", bus.mode, RUN);
        check("seq_run_en", bus.run_en, 1);
        check("clr_count_pulses", n_clr - base_clr, 1);
        check("clr_mode", mode_at_clr, RUN);
        check("pulse_exclusive", excl_err, 0);
        check("pulse_width", wide_err, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

`default_nettype wire
